stage4_mem_wb: RTL and testbench

//  Stage 4 (MEM) plus MEM/WB pipeline register of the five-stage MIPS CPU.
//  - Performs lw/sw through a req/ack data-memory port and stalls upstream while an access is outstanding.
//  - Drives the register-file write interface (regwrite, wrreg, wrdata) consumed by stage 2 (ID).

---
 rtl/stage4_mem_wb_pkg.sv | 37 +++
 rtl/stage4_mem_wb_dmem_port.sv | 119 +++++++++++
 rtl/stage4_mem_wb.sv | 97 +++++++++
 tb/tb_stage4_mem_wb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage4_mem_wb_pkg.sv
// Shared definitions for the MEM stage: FSM encodings, word-alignment mask,
// write-back record and the write-back bubble helper.
package stage4_mem_wb_pkg;

  // Data-memory port controller states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Clears the byte-offset bits to form a word address.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Default number of ACCESS cycles allowed before an access is aborted.
  localparam int DEFAULT_TIMEOUT = 16;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic        regwrite;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
  } wb_t;

  // A bubble drops the write enable but keeps wrreg/wrdata unchanged.
  function automatic wb_t wb_bubble(input wb_t cur);
    wb_t b;
    b          = cur;
    b.regwrite = 1'b0;
    return b;
  endfunction

  // Word accesses must have the two low address bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & ~WORD_ALIGN_MASK) != 32'd0;
  endfunction

endpackage

// File: rtl/stage4_mem_wb_dmem_port.sv
// Data-memory port controller: IDLE/ACCESS FSM, request registers held stable
// for the whole access, timeout counter and the sticky error flag.
module stage4_mem_wb_dmem_port
  import stage4_mem_wb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_memop,
  input  logic        i_misaligned,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_wrreg,
  input  logic        i_memtoreg,
  input  logic        i_regwrite,
  input  logic        i_ack,
  output logic        o_idle,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_req,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [4:0]  o_wrreg,
  output logic        o_memtoreg,
  output logic        o_regwrite,
  output logic        o_mem_err
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e    r_state;
  mem_state_e    w_next_state;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_timeout;
  logic          w_bad_addr;

  // State register; reset returns to IDLE, which drops dmem_req at once.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state, stall and completion decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_memop && !i_misaligned) begin
          w_accept     = 1'b1;
          o_stall      = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (i_ack) begin
          // Ack wins over a coincident timeout.
          o_done       = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          o_stall      = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_bad_addr = (r_state == ST_IDLE) && i_memop && i_misaligned;
  assign o_idle     = (r_state == ST_IDLE);
  assign o_req      = (r_state == ST_ACCESS);

  // Request registers are captured on acceptance and held through the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_wrreg    <= '0;
      o_memtoreg <= 1'b0;
      o_regwrite <= 1'b0;
    end else if (w_accept) begin
      o_we       <= i_we;
      o_addr     <= i_addr & WORD_ALIGN_MASK;
      o_wdata    <= i_wdata;
      o_wrreg    <= i_wrreg;
      o_memtoreg <= i_memtoreg;
      o_regwrite <= i_regwrite;
    end
  end

  // Timeout counter: cleared on entry to ACCESS, counts each ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_cnt <= '0;
    else if (w_accept)              r_cnt <= '0;
    else if (r_state == ST_ACCESS)  r_cnt <= r_cnt + CW'(1);
  end

  // Sticky error flag: misaligned address or aborted access; cleared by reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        o_mem_err <= 1'b0;
    else if (w_bad_addr || w_timeout) o_mem_err <= 1'b1;
  end

endmodule

// File: rtl/stage4_mem_wb.sv
// Stage 4 (MEM) of the five-stage MIPS pipeline plus the MEM/WB register.
// Loads/stores go through a req/ack data-memory port; the WB register drives
// the register-file write interface in ID.
module stage4_mem_wb
  import stage4_mem_wb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic        regwrite_in,
  input  logic [4:0]  wrreg_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        regwrite,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata,
  output logic        mem_err
);

  logic        w_memop;
  logic        w_misaligned;
  logic        w_idle;
  logic        w_done;
  logic [4:0]  w_lat_wrreg;
  logic        w_lat_memtoreg;
  logic        w_lat_regwrite;
  wb_t         r_wb;
  wb_t         w_wb_next;

  assign w_memop      = valid_in && (memread || memwrite);
  assign w_misaligned = w_memop && is_misaligned(alu_result);

  stage4_mem_wb_dmem_port #(
    .TIMEOUT (TIMEOUT)
  ) u_dmem_port (
    .clk          (clk),
    .reset        (reset),
    .i_memop      (w_memop),
    .i_misaligned (w_misaligned),
    .i_we         (memwrite),
    .i_addr       (alu_result),
    .i_wdata      (store_data),
    .i_wrreg      (wrreg_in),
    .i_memtoreg   (memtoreg),
    .i_regwrite   (regwrite_in),
    .i_ack        (dmem_ack),
    .o_idle       (w_idle),
    .o_stall      (stall),
    .o_done       (w_done),
    .o_req        (dmem_req),
    .o_we         (dmem_we),
    .o_addr       (dmem_addr),
    .o_wdata      (dmem_wdata),
    .o_wrreg      (w_lat_wrreg),
    .o_memtoreg   (w_lat_memtoreg),
    .o_regwrite   (w_lat_regwrite),
    .o_mem_err    (mem_err)
  );

  // Write-back mux: completed access, pass-through ALU op, or bubble.
  always_comb begin
    w_wb_next = wb_bubble(r_wb);
    if (w_done) begin
      w_wb_next.regwrite = w_lat_regwrite;
      w_wb_next.wrreg    = w_lat_wrreg;
      // The latched address is the latched ALU result (aligned by construction).
      w_wb_next.wrdata   = w_lat_memtoreg ? dmem_rdata : dmem_addr;
    end else if (w_idle && valid_in && !w_memop) begin
      w_wb_next.regwrite = regwrite_in;
      w_wb_next.wrreg    = wrreg_in;
      w_wb_next.wrdata   = alu_result;
    end
  end

  // MEM/WB register, loaded every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wb <= '0;
    else       r_wb <= w_wb_next;
  end

  assign regwrite = r_wb.regwrite;
  assign wrreg    = r_wb.wrreg;
  assign wrdata   = r_wb.wrdata;

endmodule

// File: tb/tb_stage4_mem_wb.sv
// Self-checking bench for stage4_mem_wb: directed scenarios followed by
// random instruction streams against a transaction-level reference model.
module tb_stage4_mem_wb;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, memread, memwrite, memtoreg, regwrite_in;
  logic [4:0]  wrreg_in;
  logic [31:0] alu_result, store_data;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic        mem_err;

  always #5 clk = ~clk;

  stage4_mem_wb #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .memread     (memread),
    .memwrite    (memwrite),
    .memtoreg    (memtoreg),
    .regwrite_in (regwrite_in),
    .wrreg_in    (wrreg_in),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .regwrite    (regwrite),
    .wrreg       (wrreg),
    .wrdata      (wrdata),
    .mem_err     (mem_err)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state: expected WB register, sticky error, memory contents.
  logic        exp_rw;
  logic [4:0]  exp_wrreg;
  logic [31:0] exp_wrdata;
  logic        exp_err;
  logic [31:0] mem_model [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_in    = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    regwrite_in = 1'b0;
    wrreg_in    = '0;
    alu_result  = '0;
    store_data  = '0;
    dmem_ack    = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic check_wb(input string tag);
    check({tag, ".regwrite"}, {31'd0, regwrite}, {31'd0, exp_rw});
    check({tag, ".wrreg"},    {27'd0, wrreg},    {27'd0, exp_wrreg});
    check({tag, ".wrdata"},   wrdata,            exp_wrdata);
    check({tag, ".mem_err"},  {31'd0, mem_err},  {31'd0, exp_err});
  endtask

  // Asynchronous reset applied mid-cycle; returns just after a rising edge.
  task automatic do_reset(input string tag);
    #2;
    idle_inputs();
    reset = 1'b1;
    #1;
    exp_rw = 1'b0; exp_wrreg = '0; exp_wrdata = '0; exp_err = 1'b0;
    check({tag, ".req"},   {31'd0, dmem_req}, 32'd0);
    check({tag, ".stall"}, {31'd0, stall},    32'd0);
    check({tag, ".addr"},  dmem_addr,         32'd0);
    check_wb(tag);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from EX/MEM, act as the memory (ack in ACCESS cycle
  // index d, never if d >= TIMEOUT), and compare against the model.
  // Called #1 after a rising edge; returns #1 after the edge that retires it.
  task automatic run_instr(input string tag, input logic valid, input logic rd,
                           input logic wr, input logic rw, input logic mtr,
                           input logic [4:0] rg, input logic [31:0] addr,
                           input logic [31:0] sd, input int d);
    logic        memop;
    logic        mis;
    logic [31:0] rd_value;
    int          served, exp_cycles;
    int          n_stall = 0, n_req = 0, extra_wr = 0, k = 0;
    bit          done = 0;

    memop = valid && (rd || wr);
    mis   = memop && (addr[1:0] != 2'b00);
    if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
    rd_value = mem_model[addr];

    served     = (d < TIMEOUT - 1) ? d : TIMEOUT - 1;
    exp_cycles = (memop && !mis) ? served + 1 : 0;

    valid_in = valid; memread = rd; memwrite = wr; memtoreg = mtr;
    regwrite_in = rw; wrreg_in = rg; alu_result = addr; store_data = sd;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      dmem_ack   = dmem_req && (k == d);
      dmem_rdata = (dmem_ack && rd) ? rd_value : $urandom;
      #1;
      if (dmem_req) begin
        n_req++;
        check({tag, ".addr"},  dmem_addr,          addr);
        check({tag, ".we"},    {31'd0, dmem_we},   {31'd0, wr});
        check({tag, ".wdata"}, dmem_wdata,         sd);
        k++;
      end
      if (stall) n_stall++;
      if (cyc > 0 && regwrite) extra_wr++;
      if (!stall) done = 1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    check({tag, ".completed"}, {31'd0, done}, 32'd1);

    // Model update: what the WB register and error flag should now hold.
    if (!valid) begin
      exp_rw = 1'b0;
    end else if (!memop) begin
      exp_rw = rw; exp_wrreg = rg; exp_wrdata = addr;
    end else if (mis) begin
      exp_rw = 1'b0; exp_err = 1'b1;
    end else if (d <= TIMEOUT - 1) begin
      exp_rw = rw; exp_wrreg = rg; exp_wrdata = mtr ? rd_value : addr;
      if (wr) mem_model[addr] = sd;
    end else begin
      exp_rw = 1'b0; exp_err = 1'b1;
    end

    check({tag, ".stall_cycles"}, n_stall,  exp_cycles);
    check({tag, ".req_cycles"},   n_req,    exp_cycles);
    check({tag, ".extra_writes"}, extra_wr, 0);
    check({tag, ".req_after"},    {31'd0, dmem_req}, 32'd0);
    check_wb(tag);
    idle_inputs();
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    logic [4:0]  r;
    int          d;

    idle_inputs();
    exp_rw = 1'b0; exp_wrreg = '0; exp_wrdata = '0; exp_err = 1'b0;
    reset = 1'b1;
    #1;
    check("reset.regwrite", {31'd0, regwrite}, 32'd0);
    check("reset.req",      {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Set the sticky error, then reset in the middle of an access.
    run_instr("pre_err", 1, 1, 0, 1, 1, 5'd3, 32'h0000_0041, 32'h0, 0);
    valid_in = 1'b1; memread = 1'b1; memtoreg = 1'b1; regwrite_in = 1'b1;
    wrreg_in = 5'd9; alu_result = 32'h0000_0300;
    repeat (3) @(posedge clk);
    #1;
    check("mid_access.req", {31'd0, dmem_req}, 32'd1);
    do_reset("mid_reset");

    // ALU op, load, store.
    run_instr("add",   1, 0, 0, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 0);
    run_instr("lw",    1, 1, 0, 1, 1, 5'd8, 32'h0000_0100, 32'h0, 2);
    run_instr("sw",    1, 0, 1, 0, 0, 5'd4, 32'h0000_0200, 32'hA5A5_A5A5, 1);
    run_instr("lw_sw", 1, 1, 0, 1, 1, 5'd6, 32'h0000_0200, 32'h0, 0);
    // Ack in the last allowed cycle wins over timeout.
    run_instr("lw_ack_last", 1, 1, 0, 1, 1, 5'd7, 32'h0000_0400, 32'h0, TIMEOUT - 1);
    run_instr("lw_misalign", 1, 1, 0, 1, 1, 5'd2, 32'h0000_0102, 32'h0, 0);
    run_instr("bubble",      0, 0, 0, 1, 0, 5'd1, 32'h0000_5555, 32'h0, 0);
    do_reset("reset2");
    run_instr("lw_timeout",  1, 1, 0, 1, 1, 5'd10, 32'h0000_0500, 32'h0, NEVER);
    run_instr("add_r0",      1, 0, 0, 1, 0, 5'd0, 32'h0000_0077, 32'h0, 0);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 59) do_reset("rnd_reset");
      kind = $urandom_range(0, 7);
      a    = 32'h0000_1000 + {26'd0, 4'($urandom), 2'b00};
      r    = 5'($urandom);
      d    = ($urandom_range(0, 5) == 0) ? TIMEOUT - 1 + $urandom_range(0, 2) : $urandom_range(0, 6);
      case (kind)
        0:       run_instr("rnd_bubble", 0, 1'($urandom), 0, 1, 0, r, $urandom, $urandom, d);
        1, 2:    run_instr("rnd_alu", 1, 0, 0, 1'($urandom), 0, r, $urandom, $urandom, d);
        3, 4:    run_instr("rnd_lw", 1, 1, 0, 1, 1, r, a, $urandom, d);
        5, 6:    run_instr("rnd_sw", 1, 0, 1, 0, 0, r, a, $urandom, d);
        default: run_instr("rnd_misalign", 1, 1'($urandom), 1, 1, 1, r,
                           a | 32'($urandom_range(1, 3)), $urandom, d);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
